// File: rtl/pipeline_stage_buffer.sv
// ---------------------------------------------------------------------------
// pipeline_stage_buffer
//
// Reusable inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) for
// the cached multi-cycle CPU. It carries PC, two data words, a destination
// register and a control bundle under a valid/ready handshake. A one-entry
// skid register keeps full throughput under back-pressure, so a stalled
// downstream stage (e.g. on a cache miss) holds the instruction instead of
// losing it.
//
// Optional build macro:
//   PIPE_STAGE_STATS_EN - adds saturating 16-bit stall/bubble counters.
//
// Ports:
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous, active-low reset
//   flush         in   synchronous flush, drops every held entry
//   in_valid      in   upstream presents an instruction
//   in_ready      out  buffer can accept (decoded from state register only)
//   in_pc         in   upstream PC            [PC_W]
//   in_data_a     in   upstream mem data      [DATA_W]
//   in_data_b     in   upstream ALU result    [DATA_W]
//   in_dst        in   destination register   [DST_W]
//   in_ctrl       in   control bundle         [CTRL_W]
//   out_valid     out  downstream payload valid
//   out_ready     in   downstream accepts this cycle
//   out_pc/out_data_a/out_data_b/out_dst/out_ctrl
//                 out  held payload, forced to 0 while out_valid=0
//   stall_cycles  out  (stats build) cycles with out_valid & !out_ready
//   bubble_cycles out  (stats build) cycles with !out_valid
// ---------------------------------------------------------------------------
module pipeline_stage_buffer #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int DST_W  = 2,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data_a,
  input  logic [DATA_W-1:0] in_data_b,
  input  logic [DST_W-1:0]  in_dst,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic [DST_W-1:0]  out_dst,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       bubble_cycles
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_in_xfer;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  logic [PC_W-1:0]   r_main_pc,     r_skid_pc;
  logic [DATA_W-1:0] r_main_data_a, r_skid_data_a;
  logic [DATA_W-1:0] r_main_data_b, r_skid_data_b;
  logic [DST_W-1:0]  r_main_dst,    r_skid_dst;
  logic [CTRL_W-1:0] r_main_ctrl,   r_skid_ctrl;

  // in_ready depends on the state register alone, never on out_ready, so no
  // combinational ready path runs backwards through the pipeline.
  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_in_xfer = in_valid & in_ready;

  // ---- control: state register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= EMPTY;
    else          r_state <= w_state_nxt;
  end

  // ---- control: next state and register load enables ----
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      // A flush discards the held entries and any same-cycle input.
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (in_valid) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = ONE;
          end
        end
        ONE: begin
          if (w_in_xfer && out_ready) begin
            w_load_main_in = 1'b1;
          end else if (w_in_xfer) begin
            // Downstream stalled: park the new entry behind main.
            w_load_skid = 1'b1;
            w_state_nxt = FULL;
          end else if (out_ready) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // ---- payload: main and skid registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main_pc     <= '0;
      r_main_data_a <= '0;
      r_main_data_b <= '0;
      r_main_dst    <= '0;
      r_main_ctrl   <= '0;
      r_skid_pc     <= '0;
      r_skid_data_a <= '0;
      r_skid_data_b <= '0;
      r_skid_dst    <= '0;
      r_skid_ctrl   <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_pc     <= in_pc;
        r_main_data_a <= in_data_a;
        r_main_data_b <= in_data_b;
        r_main_dst    <= in_dst;
        r_main_ctrl   <= in_ctrl;
      end else if (w_load_main_skid) begin
        r_main_pc     <= r_skid_pc;
        r_main_data_a <= r_skid_data_a;
        r_main_data_b <= r_skid_data_b;
        r_main_dst    <= r_skid_dst;
        r_main_ctrl   <= r_skid_ctrl;
      end
      if (w_load_skid) begin
        r_skid_pc     <= in_pc;
        r_skid_data_a <= in_data_a;
        r_skid_data_b <= in_data_b;
        r_skid_dst    <= in_dst;
        r_skid_ctrl   <= in_ctrl;
      end
    end
  end

  // Bubbles present all-zero payload so downstream decoders see a NOP.
  assign out_pc     = out_valid ? r_main_pc     : '0;
  assign out_data_a = out_valid ? r_main_data_a : '0;
  assign out_data_b = out_valid ? r_main_data_b : '0;
  assign out_dst    = out_valid ? r_main_dst    : '0;
  assign out_ctrl   = out_valid ? r_main_ctrl   : '0;

`ifdef PIPE_STAGE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;

  // ---- stats counters (cleared by reset only, flush does not touch them) ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) r_stall_cnt  <= sat_inc(r_stall_cnt);
      if (!out_valid)              r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign stall_cycles  = r_stall_cnt;
  assign bubble_cycles = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
module tb_pipeline_stage_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc;
  logic [15:0] in_data_a;
  logic [15:0] in_data_b;
  logic [1:0]  in_dst;
  logic [23:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_data_a;
  logic [15:0] out_data_b;
  logic [1:0]  out_dst;
  logic [23:0] out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] bubble_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] sbq[$];   // PCs expected at the output, in order

  always #5 clk = ~clk;

  pipeline_stage_buffer dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data_a(in_data_a), .in_data_b(in_data_b),
    .in_dst(in_dst), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_data_a(out_data_a), .out_data_b(out_data_b),
    .out_dst(out_dst), .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
  );

  // Payload fields are derived from the PC so one queue entry describes all.
  function automatic logic [15:0] f_da(input logic [15:0] pc); return pc ^ 16'hA5A5; endfunction
  function automatic logic [15:0] f_db(input logic [15:0] pc); return ~pc; endfunction
  function automatic logic [1:0]  f_dst(input logic [15:0] pc); return pc[1:0]; endfunction
  function automatic logic [23:0] f_ctrl(input logic [15:0] pc); return {8'hC3, pc}; endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample at the falling edge against the
  // queue model, update the model with the transfers of the coming edge.
  task automatic cycle(input logic v, input logic [15:0] pc, input logic rdy, input logic fl);
    logic acc;
    in_valid  = v;
    in_pc     = pc;
    in_data_a = f_da(pc);
    in_data_b = f_db(pc);
    in_dst    = f_dst(pc);
    in_ctrl   = f_ctrl(pc);
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(sbq.size() != 0));
    chk("in_ready",  64'(in_ready),  64'(sbq.size() < 2));
    if (sbq.size() != 0) begin
      chk("out_pc",     64'(out_pc),     64'(sbq[0]));
      chk("out_data_a", 64'(out_data_a), 64'(f_da(sbq[0])));
      chk("out_data_b", 64'(out_data_b), 64'(f_db(sbq[0])));
      chk("out_dst",    64'(out_dst),    64'(f_dst(sbq[0])));
      chk("out_ctrl",   64'(out_ctrl),   64'(f_ctrl(sbq[0])));
    end else begin
      chk("bubble_payload", {out_pc, out_data_a, out_data_b, out_dst, out_ctrl[13:0]}, 64'd0);
      chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
    end
    acc = v && (sbq.size() < 2);
    if (fl) begin
      sbq.delete();
    end else begin
      if (rdy && sbq.size() != 0) void'(sbq.pop_front());
      if (acc) sbq.push_back(pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 16'h0000, rdy, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sbq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_data_a = '0; in_data_b = '0; in_dst = '0; in_ctrl = '0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    do_reset();

    // Streaming at full rate
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0010 + 16'(i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure into the skid, input ignored while FULL, then drain
    cycle(1'b1, 16'h0020, 1'b0, 1'b0);
    cycle(1'b1, 16'h0022, 1'b0, 1'b0);
    cycle(1'b1, 16'h0024, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Accept while downstream drains from ONE, then refill FULL and drain mixed
    cycle(1'b1, 16'h0026, 1'b0, 1'b0);
    cycle(1'b1, 16'h0027, 1'b1, 1'b0);
    cycle(1'b1, 16'h0028, 1'b0, 1'b0);
    cycle(1'b1, 16'h0029, 1'b1, 1'b0);
    cycle(1'b1, 16'h002A, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush in FULL with a same-cycle input that must be discarded
    cycle(1'b1, 16'h0031, 1'b0, 1'b0);
    cycle(1'b1, 16'h0032, 1'b0, 1'b0);
    cycle(1'b1, 16'h0030, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with out_ready in ONE: nothing retained
    cycle(1'b1, 16'h0035, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b1);
    idle(1'b1);

    // Drain: single instruction, valid for exactly one cycle
    cycle(1'b1, 16'h0040, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset in the middle of FULL
    cycle(1'b1, 16'h0050, 1'b0, 1'b0);
    cycle(1'b1, 16'h0052, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready",  64'(in_ready),  64'd1);
    chk("async_rst_out_pc",    64'(out_pc),    64'd0);
    chk("async_rst_out_ctrl",  64'(out_ctrl),  64'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    // Skid must not survive: a fresh entry is the only one seen
    cycle(1'b1, 16'h0060, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

`ifdef PIPE_STAGE_STATS_EN
    do_reset();
    chk("stall_after_reset", 64'(stall_cycles), 64'd0);
    cycle(1'b1, 16'h0070, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    chk("stall_count_5", 64'(stall_cycles), 64'd5);
    cycle(1'b0, 16'h0000, 1'b1, 1'b1);
    chk("stall_after_flush", 64'(stall_cycles), 64'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    chk("bubble_saturated", 64'(bubble_cycles), 64'hFFFF);
    chk("stall_still_5", 64'(stall_cycles), 64'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_buffer.md
Name: pipeline_stage_buffer

Overview:
Parametrised inter-stage pipeline register for the cached multi-cycle CPU, generalising the fixed MEM/WB latch into a reusable stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries PC, two data words and a control bundle under a valid/ready handshake. A one-entry skid buffer gives full throughput under back-pressure, and a synchronous flush inserts bubbles. It replaces the "zero-on-stall" behaviour with a true hold, so no instruction is lost while a downstream stage (e.g. a cache miss) stalls.

Parameters:
PC_W, 16, width of PC field
DATA_W, 16, width of each of the two data fields (mem data, ALU result)
DST_W, 2, width of destination-register field
CTRL_W, 24, width of control-signal bundle

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush; drops all held entries
in_valid  in  1  upstream presents a valid instruction
in_ready  out  1  buffer can accept; registered, not combinational from out_ready
in_pc  in  PC_W  upstream PC
in_data_a  in  DATA_W  upstream data word A (mem data)
in_data_b  in  DATA_W  upstream data word B (ALU result)
in_dst  in  DST_W  upstream destination register
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  downstream payload is valid
out_ready  in  1  downstream accepts this cycle
out_pc  out  PC_W  held PC
out_data_a  out  DATA_W  held data A
out_data_b  out  DATA_W  held data B
out_dst  out  DST_W  held destination register
out_ctrl  out  CTRL_W  held control bundle

Behaviour:
- Reset: clk and reset_n are already decided; reset_n is asynchronous, active-low. On reset: state=EMPTY, in_ready=1, out_valid=0, all payload outputs 0, skid entry cleared.
- Storage: main register (drives outputs) plus one skid register. Transfer in = in_valid&in_ready; transfer out = out_valid&out_ready.
- States: EMPTY (0 entries), ONE (main valid), FULL (main+skid valid). in_ready = (state!=FULL), registered.
- EMPTY: in_valid -> main<=in, ONE; else stay.
- ONE: in xfer & out_ready -> main<=in, stay ONE (1 instr/cycle). in xfer & !out_ready -> skid<=in, FULL. !in_valid & out_ready -> EMPTY. Neither -> hold.
- FULL: out_ready -> main<=skid, ONE, in_ready rises next cycle. Else hold. in_valid ignored.
- Ordering: strictly FIFO; skid never bypasses main.
- Latency: 1 cycle from input accept to out_valid when downstream is not stalled.
- Bubble: payload outputs read 0 whenever out_valid=0, so downstream decoders see NOP-equivalent control.
- Flush: highest priority below reset. Next edge: state=EMPTY, out_valid=0, in_ready=1. Same-cycle in_valid is discarded. Flush with out_ready: the current output counts as consumed by downstream; the buffer retains nothing.
- Reset mid-operation: immediate asynchronous clear regardless of state; no partial entries survive.
- No arithmetic; all fields pass through bit-exact.

Optional Feature:
PIPE_STAGE_STATS_EN: when defined, adds outputs stall_cycles[15:0] and bubble_cycles[15:0].
- stall_cycles increments each cycle with out_valid&!out_ready.
- bubble_cycles increments each cycle with !out_valid.
- Both counters saturate at 16'hFFFF, clear on reset only, and are unaffected by flush.
- When the macro is undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert reset_n=0 mid-FULL -> out_valid=0, in_ready=1, out_pc=0, out_ctrl=0 immediately, without waiting for a clock edge.
- Streaming: out_ready=1, present PC 0x0010..0x0014 on 5 consecutive cycles -> out_pc shows the same sequence one cycle later, no gaps, in_ready stays 1.
- Back-pressure: send 0x0020 and 0x0022 while out_ready=0 -> out_pc=0x0020 held, in_ready=0 after the second accept. Raise out_ready -> 0x0020 then 0x0022 emerge, in_ready=1 again.
- Flush in FULL with in_valid=1 (PC 0x0030) -> next cycle out_valid=0, all outputs 0, 0x0030 never appears at the output.
- Drain: single input 0x0040 with out_ready=1 and no further inputs -> out_valid high for exactly one cycle, then the payload reads 0.
- Stats (macro on): hold out_valid=1 with out_ready=0 for 5 cycles -> stall_cycles=5. Flush -> count unchanged. 70000 idle cycles -> bubble_cycles=16'hFFFF.
